multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, giving the word-address width of the instruction memory (8192 words).
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port mem_req, output, 1 bit: instruction fetch request.
REQ-007 Port mem_addr, output, ADDR_WIDTH bits: fetch word address.
REQ-008 Port mem_ack, input, 1 bit: fetch data valid.
REQ-009 Port mem_rdata, input, 32 bits: fetched instruction.
REQ-010 Port halted, output, 1 bit: core stopped.
REQ-011 Port flags, output, 4 bits: {N,Z,C,V}.
REQ-012 Port dbg_sel, input, 4 bits: register select for debug read.
REQ-013 Port dbg_data, output, 32 bits: combinational r[dbg_sel].

Function
REQ-014 The block SHALL hold 16 32-bit registers r0-r15, with r15 as the PC; the PC SHALL be ADDR_WIDTH bits, zero-extended on reads.
REQ-015 The FSM SHALL have three states: FETCH, EXECUTE and HALT.
REQ-016 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal the PC, held stable until mem_ack is sampled 1.
REQ-017 On mem_ack=1 in FETCH: IR<=mem_rdata, PC<=PC+1 (wrapping modulo 2^ADDR_WIDTH), next state EXECUTE; mem_req SHALL be 0 in the following cycle.
REQ-018 mem_ack SHALL be ignored whenever the state is not FETCH; minimum throughput SHALL be 2 cycles per instruction.
REQ-019 Decode fields: cond=[31:28], I=[25], opcode=[24:21], S=[20], rn=[19:16], rd=[15:12], op2=[11:0].
REQ-020 Operand 2 with I=1: zero-extended [7:0] rotated right by 2*[11:8]; with I=0: r[op2[3:0]].
REQ-021 Reading r15 as an operand SHALL return the already-incremented PC.
REQ-022 Condition codes: EQ 0000 (Z), NE 0001 (!Z), CS 0010 (C), CC 0011 (!C), MI 0100 (N), PL 0101 (!N), AL 1110 (true); all others except 1111 SHALL be false, i.e. no-op.
REQ-023 cond=1111 SHALL enter HALT: halted=1, mem_req=0; HALT SHALL be left only by rst.
REQ-024 Opcodes: AND 0000, EOR 0001, SUB 0010 (rn-op2), ADD 0100, CMP 1010 (rn-op2, no write, flags always updated), ORR 1100, MOV 1101 (op2); any other opcode SHALL be a no-op.
REQ-025 In EXECUTE with a true condition, the result SHALL be written to r[rd]; flags SHALL be updated if S=1 or CMP; the next state SHALL be FETCH.
REQ-026 Flags: N=result[31]; Z=(result==0).
REQ-027 ADD flags: C=carry out; V=signed overflow.
REQ-028 SUB/CMP flags: C=1 when no borrow (rn>=op2 unsigned); V=signed overflow.
REQ-029 Logical ops and MOV SHALL leave C and V unchanged.
REQ-030 A write with rd=15 SHALL load PC<=result[ADDR_WIDTH-1:0], overriding the increment (branch); the next fetch SHALL use the new PC.

Reset
REQ-031 On rst=1, at the next edge: state=FETCH; PC=RESET_PC; r0-r14=0; IR=0; flags=0000; halted=0; mem_req=0 in the reset cycle, then 1 in the first cycle after rst falls.
REQ-032 rst SHALL take priority over mem_ack and over every state, including a fetch in flight or HALT; a mem_ack coincident with rst SHALL be discarded.

Verification
REQ-033 Reset, then fetch 0xE3A01005 (MOV r1,#5) with ack one cycle after req -> r1=5, flags=0000, next mem_addr=1.
REQ-034 Fetch 0xE3A01102 (MOV r1,#0x80000000), then 0xE2512001 (SUBS r2,r1,#1) -> r2=0x7FFFFFFF, flags N=0 Z=0 C=1 V=1.
REQ-035 With r1=5: fetch 0xE3510005 (CMP), 0x03A03007 (MOVEQ r3,#7), 0x13A04009 (MOVNE r4,#9) -> Z=1, C=1, r3=7, r4=0.
REQ-036 Fetch 0xE3A0F008 at address 0 -> the next request has mem_addr=8.
REQ-037 Hold mem_ack=0 for 5 cycles during FETCH -> mem_req stays 1, mem_addr is constant, and registers and flags are unchanged.
REQ-038 Fetch 0xF0000000 -> halted=1 and mem_req=0 for 20 cycles, ignoring a spurious mem_ack; then pulse rst -> halted=0 and a fetch from RESET_PC.

Source files
------------

// File: rtl/multicycle_core.sv
// Multicycle 32-bit core with a two-cycle fetch/execute loop over an ARM-like subset.
// r15 is the ADDR_WIDTH-bit PC; a cond field of 1111 halts the core until reset.
module multicycle_core #(
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  halted,
  output logic [3:0]            flags,
  input  logic [3:0]            dbg_sel,
  output logic [31:0]           dbg_data,
  output logic [1:0]            dbg_state
);

  // Fetch handshake: mem_req is held with a stable mem_addr until the first
  // cycle mem_ack is sampled high; that edge transfers the instruction.
  // mem_ack is ignored in every other state and whenever rst is high.
  typedef enum logic [1:0] {FETCH = 2'd0, EXECUTE = 2'd1, HALT = 2'd2} state_t;

  state_t                state, state_next;
  logic [31:0]           regs [16];
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           ir;
  logic [31:0]           pc_ext;

  logic [3:0]  cond, opcode, rn, rd;
  logic        imm_sel, set_flags;
  logic [31:0] rn_val, op2, result;
  logic [63:0] imm_rot;
  logic [32:0] sum;
  logic [31:0] diff;
  logic        cond_true, op_valid, is_cmp, is_add, is_sub;
  logic        exec_en, wr_en, flag_en;
  logic [3:0]  flags_next;
  logic        unused_ir;

  assign cond      = ir[31:28];
  assign imm_sel   = ir[25];
  assign opcode    = ir[24:21];
  assign set_flags = ir[20];
  assign rn        = ir[19:16];
  assign rd        = ir[15:12];
  assign unused_ir = &{1'b0, ir[27:26]};

  assign pc_ext    = {{(32-ADDR_WIDTH){1'b0}}, pc};
  assign mem_req   = (state == FETCH) && !rst;
  assign mem_addr  = pc;
  assign halted    = (state == HALT);
  assign dbg_state = state;
  assign dbg_data  = (dbg_sel == 4'd15) ? pc_ext : regs[dbg_sel];

  always_comb begin
    imm_rot    = '0;
    rn_val     = '0;
    op2        = '0;
    sum        = '0;
    diff       = '0;
    result     = '0;
    cond_true  = 1'b0;
    op_valid   = 1'b0;
    is_cmp     = 1'b0;
    is_add     = 1'b0;
    is_sub     = 1'b0;
    flags_next = flags;
    state_next = state;

    // r15 reads as the PC, which has already been incremented by the fetch
    rn_val  = (rn == 4'd15) ? pc_ext : regs[rn];
    imm_rot = {24'd0, ir[7:0], 24'd0, ir[7:0]} >> {ir[11:8], 1'b0};
    if (imm_sel) op2 = imm_rot[31:0];
    else         op2 = (ir[3:0] == 4'd15) ? pc_ext : regs[ir[3:0]];

    sum  = {1'b0, rn_val} + {1'b0, op2};
    diff = rn_val - op2;

    case (cond)
      4'h0:    cond_true = flags[2];
      4'h1:    cond_true = !flags[2];
      4'h2:    cond_true = flags[1];
      4'h3:    cond_true = !flags[1];
      4'h4:    cond_true = flags[3];
      4'h5:    cond_true = !flags[3];
      4'he:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase

    case (opcode)
      4'b0000: begin result = rn_val & op2; op_valid = 1'b1; end
      4'b0001: begin result = rn_val ^ op2; op_valid = 1'b1; end
      4'b0010: begin result = diff; op_valid = 1'b1; is_sub = 1'b1; end
      4'b0100: begin result = sum[31:0]; op_valid = 1'b1; is_add = 1'b1; end
      4'b1010: begin result = diff; op_valid = 1'b1; is_sub = 1'b1; is_cmp = 1'b1; end
      4'b1100: begin result = rn_val | op2; op_valid = 1'b1; end
      4'b1101: begin result = op2; op_valid = 1'b1; end
      default: result = '0;
    endcase

    flags_next[3] = result[31];
    flags_next[2] = (result == 32'd0);
    if (is_add) begin
      flags_next[1] = sum[32];
      flags_next[0] = (rn_val[31] == op2[31]) && (result[31] != rn_val[31]);
    end else if (is_sub) begin
      flags_next[1] = (rn_val >= op2);
      flags_next[0] = (rn_val[31] != op2[31]) && (result[31] != rn_val[31]);
    end

    case (state)
      FETCH:   if (mem_ack) state_next = EXECUTE;
      EXECUTE: state_next = (cond == 4'hf) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign exec_en = (state == EXECUTE) && (cond != 4'hf) && cond_true && op_valid;
  assign wr_en   = exec_en && !is_cmp;
  assign flag_en = exec_en && (set_flags || is_cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      flags <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && mem_ack) begin
        ir <= mem_rdata;
        pc <= pc + 1'b1;
      end
      if (wr_en) begin
        // a write to r15 is a branch and replaces the post-fetch increment
        if (rd == 4'd15) pc <= result[ADDR_WIDTH-1:0];
        else             regs[rd] <= result;
      end
      if (flag_en) flags <= flags_next;
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: a hand-driven instruction memory and
// hand-computed register, flag and address expectations.
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        halted;
  logic [3:0]  flags;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_core #(.ADDR_WIDTH(13), .RESET_PC(13'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .halted    (halted),
    .flags     (flags),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Waits for a request, delays the ack, then returns once the execute cycle is done.
  task automatic do_fetch(input logic [31:0] instr, input int delay);
    int n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (mem_req !== 1'b1) check("fetch_timeout", {31'd0, mem_req}, 32'd1);
    repeat (delay) @(negedge clk);
    mem_rdata = instr;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; dbg_sel = '0;
    repeat (2) @(negedge clk);
    check("reset_req",    {31'd0, mem_req}, 32'd0);
    check("reset_halted", {31'd0, halted},  32'd0);
    check("reset_flags",  {28'd0, flags},   32'd0);
    check("reset_addr",   {19'd0, mem_addr}, 32'd0);
    chk_reg("reset_r0", 4'd0, 32'd0);
    rst = 1'b0;
    #1;
    check("req_after_rst", {31'd0, mem_req}, 32'd1);

    // MOV r1,#5 at address 0 with the ack one cycle after the request
    do_fetch(32'hE3A01005, 1);
    chk_reg("mov_r1", 4'd1, 32'd5);
    check("mov_flags", {28'd0, flags}, 32'd0);
    check("mov_next_addr", {19'd0, mem_addr}, 32'd1);
    chk_reg("r15_pc", 4'd15, 32'd1);

    // MOV r1,#0x80000000 ; SUBS r2,r1,#1
    do_fetch(32'hE3A01102, 0);
    chk_reg("mov_rot_r1", 4'd1, 32'h80000000);
    do_fetch(32'hE2512001, 2);
    chk_reg("subs_r2", 4'd2, 32'h7FFFFFFF);
    check("subs_flags", {28'd0, flags}, 32'h3);

    // MOV r1,#5 ; CMP r1,#5 ; MOVEQ r3,#7 ; MOVNE r4,#9
    do_fetch(32'hE3A01005, 0);
    do_fetch(32'hE3510005, 0);
    check("cmp_flags", {28'd0, flags}, 32'h6);
    do_fetch(32'h03A03007, 0);
    do_fetch(32'h13A04009, 0);
    chk_reg("moveq_r3", 4'd3, 32'd7);
    chk_reg("movne_r4", 4'd4, 32'd0);
    check("cond_mov_flags", {28'd0, flags}, 32'h6);

    // ADDS r5,r2,#1 overflows into the sign bit
    do_fetch(32'hE2925001, 0);
    chk_reg("adds_r5", 4'd5, 32'h80000000);
    check("adds_flags", {28'd0, flags}, 32'h9);
    // EOR r6,r5,r2 (register operand, no flag update)
    do_fetch(32'hE0256002, 0);
    chk_reg("eor_r6", 4'd6, 32'hFFFFFFFF);
    check("eor_flags", {28'd0, flags}, 32'h9);
    // ANDS r7,r6,#0 sets Z and keeps C and V
    do_fetch(32'hE2167000, 0);
    chk_reg("ands_r7", 4'd7, 32'd0);
    check("ands_flags", {28'd0, flags}, 32'h5);
    // MOV r8,r15 at address 10 reads the incremented PC
    do_fetch(32'hE1A0800F, 0);
    chk_reg("mov_r8_pc", 4'd8, 32'd11);
    // cond 1000 never executes; opcode 0011 is a no-op
    do_fetch(32'h83A09001, 0);
    chk_reg("never_r9", 4'd9, 32'd0);
    do_fetch(32'hE2711001, 0);
    chk_reg("undef_op_r1", 4'd1, 32'd5);
    check("undef_op_flags", {28'd0, flags}, 32'h5);

    // Stall: no ack for 5 cycles at address 13
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req",   {31'd0, mem_req},  32'd1);
      check("stall_addr",  {19'd0, mem_addr}, 32'd13);
      check("stall_flags", {28'd0, flags},    32'h5);
      chk_reg("stall_r1", 4'd1, 32'd5);
    end

    // Halt, then spurious acks must be ignored
    do_fetch(32'hF0000000, 0);
    check("halt_state", {30'd0, dbg_state}, 32'd2);
    for (int i = 0; i < 20; i++) begin
      mem_ack   = (i % 3 == 0);
      mem_rdata = 32'hE3A01009;
      @(negedge clk);
      check("halt_halted", {31'd0, halted},  32'd1);
      check("halt_req",    {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;
    chk_reg("halt_r1", 4'd1, 32'd5);
    check("halt_addr", {19'd0, mem_addr}, 32'd14);

    // Reset pulse with a coincident ack that must be discarded
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hE3A01009;
    @(negedge clk);
    check("rst_req",    {31'd0, mem_req}, 32'd0);
    check("rst_halted", {31'd0, halted},  32'd0);
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    check("rst2_req",  {31'd0, mem_req},  32'd1);
    check("rst2_addr", {19'd0, mem_addr}, 32'd0);
    chk_reg("rst2_r1", 4'd1, 32'd0);
    check("rst2_flags", {28'd0, flags}, 32'd0);

    // MOV pc,#8 at address 0 branches; next fetch comes from 8
    do_fetch(32'hE3A0F008, 1);
    check("branch_addr", {19'd0, mem_addr}, 32'd8);
    check("branch_req",  {31'd0, mem_req},  32'd1);
    do_fetch(32'hE3A01009, 0);
    chk_reg("post_branch_r1", 4'd1, 32'd9);
    check("post_branch_addr", {19'd0, mem_addr}, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
